// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width, counter width,
// state encoding and a two's-complement magnitude helper (used when SIGNED_MULT_EN is defined).
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // |-128| = 128 still fits in an unsigned MULT_WIDTH-bit value.
  function automatic logic [MULT_WIDTH-1:0] magnitude(input logic [MULT_WIDTH-1:0] v);
    return v[MULT_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/shift_add_mult8_if.sv
// Start/busy/done handshake plus operands and product of the multiplier.
// The master drives the request; the slave (the multiplier) answers.
interface shift_add_mult8_if;
  import mult_pkg::*;

  logic                      start;
  logic [MULT_WIDTH-1:0]     a;
  logic [MULT_WIDTH-1:0]     b;
  logic                      busy;
  logic                      done;
  logic [2*MULT_WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/ripple_adder_n.sv
// WIDTH-bit ripple-carry adder built from a chain of full adders.
module ripple_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 shift-and-add multiplier, one partial-sum addition per clock.
// Define SIGNED_MULT_EN to treat operands as two's complement.
module shift_add_mult8
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  shift_add_mult8_if.slave bus
);

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     acc_hi_q;
  logic [WIDTH-1:0]     acc_lo_q;
  logic [CNT_W-1:0]     count_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shift_d;
  logic [2*WIDTH-1:0]   result_d;
  logic [WIDTH-1:0]     op_a_d;
  logic [WIDTH-1:0]     op_b_d;

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // 17-bit {cout, sum, acc_lo} shifted right by one, keeping the low 16 bits.
  assign shift_d = {cout, sum, acc_lo_q[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
  logic sign_q;

  assign op_a_d   = magnitude(bus.a);
  assign op_b_d   = magnitude(bus.b);
  assign result_d = sign_q ? -shift_d : shift_d;
`else
  assign op_a_d   = bus.a;
  assign op_b_d   = bus.b;
  assign result_d = shift_d;
`endif

  // NOTE: every register here is written with <= so all of them update from the
  // values present before the edge; mixing in = would make results order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SIGNED_MULT_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mcand_q  <= op_a_d;
            acc_hi_q <= '0;
            acc_lo_q <= op_b_d;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
`ifdef SIGNED_MULT_EN
            sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          {acc_hi_q, acc_lo_q} <= shift_d;
          count_q              <= count_q + 1'b1;
          // Product is written only here, so it never shows a partial result.
          if (count_q == CNT_W'(WIDTH - 1)) begin
            product_q <= result_d;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed-vector bench for shift_add_mult8 with a cycle-level reference model
// compared on every falling edge.
module tb_shift_add_mult8;

  logic clk;
  logic rst;
  logic chk_en;

  int vectors;
  int miscompares;
  int done_cnt;

  shift_add_mult8_if bus ();

  shift_add_mult8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the arithmetic definition.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int xi;
    int yi;
`ifdef SIGNED_MULT_EN
    xi = int'($signed(x));
    yi = int'($signed(y));
`else
    xi = int'(x);
    yi = int'(y);
`endif
    return 16'(xi * yi);
  endfunction

  // Model: an accepted op keeps the unit busy for 9 cycles, the last one being done.
  int          m_left;
  logic [15:0] m_pending;
  logic [15:0] m_product;

  always @(posedge clk) begin
    if (rst) begin
      m_left    <= 0;
      m_product <= '0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_left    <= 9;
        m_pending <= ref_mul(bus.a, bus.b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_product <= m_pending;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(bus.busy),    32'(m_left != 0));
      check("done",    32'(bus.done),    32'(m_left == 1));
      check("product", 32'(bus.product), 32'(m_product));
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk); #1;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_p);
    int lat;
    int d0;
    d0 = done_cnt;
    start_op(av, bv);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'd8);
    check({name, "_product"}, 32'(bus.product), 32'(exp_p));
    @(posedge clk); #1;
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int lat;
    int d0;
    int done_at[$];

    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_busy",    32'(bus.busy),    32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    rst = 1'b0;

    // Basic operation, handshake and latency.
    start_op(8'd13, 8'd11);
    check("t1_busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_product", 32'(bus.product), 32'h008F);
    @(posedge clk); #1;
    check("t1_busy_after_done", 32'(bus.busy), 32'd0);

    // Extremes.
    run_op("t2_max",  8'd255, 8'd255, 16'hFE01);
    run_op("t2_zero", 8'd0,   8'd200, 16'h0000);

    // Start while busy is ignored.
    d0 = done_cnt;
    start_op(8'd7, 8'd9);
    @(posedge clk);
    @(posedge clk); #1;
    bus.a     = 8'd100;
    bus.b     = 8'd100;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'd5);
    check("t3_product", 32'(bus.product), 32'h003F);
    repeat (12) @(posedge clk);
    #1;
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset mid-operation aborts without a done pulse.
    start_op(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_busy",    32'(bus.busy),    32'd0);
    check("t4_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    d0  = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    run_op("t4_after", 8'd2, 8'd3, 16'h0006);

    // Back-to-back with start held high.
    bus.a     = 8'd5;
    bus.b     = 8'd6;
    bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        done_at.push_back(c);
        check("t5_product", 32'(bus.product), 32'h001E);
      end
    end
    bus.start = 1'b0;
    check("t5_done_count", 32'(done_at.size()), 32'd4);
    for (int i = 1; i < done_at.size(); i++)
      check("t5_period", 32'(done_at[i] - done_at[i-1]), 32'd10);
    repeat (12) @(posedge clk);

`ifdef SIGNED_MULT_EN
    run_op("t6_neg3x5",    8'hFD, 8'd5,  16'hFFF1);
    run_op("t6_m128xm128", 8'h80, 8'h80, 16'h4000);
    run_op("t6_127xm1",    8'd127, 8'hFF, 16'hFF81);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
